// File: rtl/imm_gen_pipe.sv
// Purpose: decode-stage immediate generator; formats I/S/B/U/J/R/Z/SH, sign/zero extended to XLEN.
// Latency: one cycle from accept to out_valid; sustains one result per cycle while out_ready=1.
// Backpressure: SKID=1 holds up to two entries with a registered in_ready; SKID=0 holds one.
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [31:0]     out_instr
);

  // Immediate format select encoding.
  localparam logic [2:0] IMM_I  = 3'd0;
  localparam logic [2:0] IMM_S  = 3'd1;
  localparam logic [2:0] IMM_B  = 3'd2;
  localparam logic [2:0] IMM_U  = 3'd3;
  localparam logic [2:0] IMM_J  = 3'd4;
  localparam logic [2:0] IMM_R  = 3'd5;
  localparam logic [2:0] IMM_Z  = 3'd6;
  localparam logic [2:0] IMM_SH = 3'd7;

  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_accept;
  logic            w_xfer;

  logic            r_main_vld;
  logic [XLEN-1:0] r_main_imm;
  logic [31:0]     r_main_instr;
  logic            r_skid_vld;
  logic [XLEN-1:0] r_skid_imm;
  logic [31:0]     r_skid_instr;

  // Build the 32-bit immediate. Every signed format carries its sign in
  // instr[31], which lands in bit 31 here; R/Z/SH always leave bit 31 clear,
  // so a single sign extension of bit 31 below is correct for all formats.
  always_comb begin
    w_imm32 = '0;
    case (in_imm_src)
      IMM_I:  w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      IMM_S:  w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_B:  w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
      IMM_U:  w_imm32 = {in_instr[31:12], 12'b0};
      IMM_J:  w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
      IMM_R:  w_imm32 = '0;
      IMM_Z:  w_imm32 = {27'b0, in_instr[19:15]};
      IMM_SH: w_imm32 = (XLEN == 64) ? {26'b0, in_instr[25:20]}
                                     : {27'b0, in_instr[24:20]};
    endcase
  end

  // Widen to XLEN; RV64 replicates bit 31 into the upper word.
  generate
    if (XLEN == 64) begin : g_rv64
      assign w_imm = {{32{w_imm32[31]}}, w_imm32};
    end else begin : g_rv32
      assign w_imm = w_imm32;
    end
  endgenerate

  // With the skid buffer, ready is just the flop !skid_valid, so out_ready
  // never reaches in_ready combinationally.
  assign in_ready  = (SKID != 0) ? !r_skid_vld : (!r_main_vld || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = r_main_vld && out_ready;

  assign out_valid = r_main_vld;
  assign out_imm   = r_main_imm;
  assign out_instr = r_main_instr;

  // Main/skid storage: rst clears everything, flush drops entries and blocks
  // the same-cycle input; otherwise skid refills main first, then new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_vld   <= 1'b0;
      r_main_imm   <= '0;
      r_main_instr <= '0;
      r_skid_vld   <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_instr <= '0;
    end else if (flush) begin
      r_main_vld   <= 1'b0;
      r_skid_vld   <= 1'b0;
    end else if (r_skid_vld) begin
      // in_ready is low here, so no accept can coincide with this move.
      if (w_xfer) begin
        r_main_imm   <= r_skid_imm;
        r_main_instr <= r_skid_instr;
        r_skid_vld   <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_main_vld || w_xfer) begin
        r_main_vld   <= 1'b1;
        r_main_imm   <= w_imm;
        r_main_instr <= in_instr;
      end else begin
        r_skid_vld   <= 1'b1;
        r_skid_imm   <= w_imm;
        r_skid_instr <= in_instr;
      end
    end else if (w_xfer) begin
      r_main_vld   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: RV32 and RV64 instances (both SKID=1) share stimulus.
// A queue model of the two-entry buffer plus a per-format immediate function
// is checked every cycle; directed vectors carry hand-computed literals.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_src;

  logic        in_ready32, out_valid32;
  logic [31:0] out_imm32, out_instr32;
  logic        in_ready64, out_valid64;
  logic [63:0] out_imm64;
  logic [31:0] out_instr64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SKID(1)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_instr(out_instr32));

  imm_gen_pipe #(.XLEN(64), .SKID(1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_instr(out_instr64));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Immediate straight from the ISA field definitions, using signed arithmetic.
  function automatic logic [63:0] model_imm(input logic [31:0] ins, input logic [2:0] src,
                                            input int xlen);
    logic signed [63:0] v;
    v = '0;
    case (src)
      3'd0: v = $signed(ins[31:20]);
      3'd1: v = $signed({ins[31:25], ins[11:7]});
      3'd2: v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      3'd3: v = $signed({ins[31:12], 12'b0});
      3'd4: v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      3'd5: v = '0;
      3'd6: v = {59'd0, ins[19:15]};
      3'd7: if (xlen == 64) v = {58'd0, ins[25:20]};
            else            v = {59'd0, ins[24:20]};
    endcase
    if (xlen == 32) v[63:32] = '0;
    return v;
  endfunction

  // Behavioural model: an in-order queue of at most two entries.
  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
  } ent_t;
  ent_t q[$];
  bit   live = 1'b0;
  bit   m_acc, m_xf;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      live = 1'b1;
    end else if (live) begin
      m_acc = in_valid && !flush && (q.size() < 2);
      m_xf  = (q.size() > 0) && out_ready;
      if (flush) q.delete();
      else begin
        if (m_xf)  void'(q.pop_front());
        if (m_acc) q.push_back('{instr: in_instr, src: in_imm_src});
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (live) begin
      chk("in_ready32",  64'(in_ready32),  64'(q.size() < 2));
      chk("in_ready64",  64'(in_ready64),  64'(q.size() < 2));
      chk("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
      chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
      if (q.size() > 0) begin
        chk("out_imm32",   64'(out_imm32),   model_imm(q[0].instr, q[0].src, 32));
        chk("out_imm64",   out_imm64,        model_imm(q[0].instr, q[0].src, 64));
        chk("out_instr32", 64'(out_instr32), 64'(q[0].instr));
        chk("out_instr64", 64'(out_instr64), 64'(q[0].instr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src);
    in_valid   = v;
    in_instr   = ins;
    in_imm_src = src;
  endtask

  // Directed vector table: instr, src, expected RV32, expected RV64.
  localparam int NV = 10;
  logic [31:0] v_ins [NV] = '{32'hFFF00093, 32'hFE000EE3, 32'h800000B7, 32'h12345037,
                              32'h000FD073, 32'h03F0D093, 32'hFFFFFFFF, 32'h80000F80,
                              32'h8000006F, 32'h7FF00013};
  logic [2:0]  v_src [NV] = '{3'd0, 3'd2, 3'd3, 3'd3, 3'd6, 3'd7, 3'd5, 3'd1, 3'd4, 3'd0};
  logic [31:0] v_e32 [NV] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h80000000, 32'h12345000,
                              32'h0000001F, 32'h0000001F, 32'h00000000, 32'hFFFFF81F,
                              32'hFFF00000, 32'h000007FF};
  logic [63:0] v_e64 [NV] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000,
                              64'h0000000012345000, 64'h000000000000001F, 64'h000000000000003F,
                              64'h0, 64'hFFFFFFFFFFFFF81F, 64'hFFFFFFFFFFF00000,
                              64'h00000000000007FF};

  logic [31:0] got[$];
  logic [15:0] rdy_pat;
  bit          acc;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 3'd0);
    step(); step();
    chk("rst_out_valid", 64'(out_valid32), 64'd0);
    chk("rst_out_imm64", out_imm64, 64'd0);
    chk("rst_out_instr", 64'(out_instr32), 64'd0);
    chk("rst_in_ready",  64'(in_ready32), 64'd1);
    rst = 1'b0;

    // Pin the model against the hand-computed table.
    for (int i = 0; i < NV; i++) begin
      chk("model32", model_imm(v_ins[i], v_src[i], 32), 64'(v_e32[i]));
      chk("model64", model_imm(v_ins[i], v_src[i], 64), v_e64[i]);
    end

    // Back-to-back stream: each result one cycle after its accept.
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, v_ins[i], v_src[i]);
      step();
      chk("vec_valid", 64'(out_valid32), 64'd1);
      chk("vec_imm32", 64'(out_imm32), 64'(v_e32[i]));
      chk("vec_imm64", out_imm64, v_e64[i]);
    end
    drive(1'b0, 32'h0, 3'd0);
    step();
    chk("vec_drained", 64'(out_valid32), 64'd0);

    // Backpressure: A, B fill main and skid; C is held off until skid drains.
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'd0); step();
    drive(1'b1, 32'h7FF00013, 3'd0); step();
    chk("bp_full_rdy", 64'(in_ready32), 64'd0);
    drive(1'b1, 32'h000FD073, 3'd6); step(); step();
    chk("bp_hold_rdy",   64'(in_ready32), 64'd0);
    chk("bp_stable_imm", 64'(out_imm32), 64'hFFFFFFFF);
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      if (out_valid32) got.push_back(out_imm32);
      acc = in_valid && in_ready32;
      step();
      if (acc) in_valid = 1'b0;
    end
    chk("bp_count", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      chk("bp_order0", 64'(got[0]), 64'hFFFFFFFF);
      chk("bp_order1", 64'(got[1]), 64'h000007FF);
      chk("bp_order2", 64'(got[2]), 64'h0000001F);
    end

    // Flush with both entries full and an input offered the same cycle.
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'd0); step();
    drive(1'b1, 32'h7FF00013, 3'd0); step();
    drive(1'b1, 32'h12345037, 3'd3); flush = 1'b1; step();
    flush = 1'b0;
    chk("fl_valid", 64'(out_valid32), 64'd0);
    chk("fl_ready", 64'(in_ready32), 64'd1);
    drive(1'b1, 32'h03F0D093, 3'd7); step();
    drive(1'b0, 32'h0, 3'd0);
    chk("fl_next_valid", 64'(out_valid64), 64'd1);
    chk("fl_next_imm32", 64'(out_imm32), 64'd31);
    chk("fl_next_imm64", out_imm64, 64'd63);
    out_ready = 1'b1; step();
    chk("fl_no_stale", 64'(out_valid32), 64'd0);

    // Reset mid-operation with out_ready toggling.
    out_ready = 1'b0;
    drive(1'b1, 32'h800000B7, 3'd3); step();
    drive(1'b1, 32'h8000006F, 3'd4); step();
    chk("rm_pre_imm64", out_imm64, 64'hFFFFFFFF80000000);
    drive(1'b1, 32'hFFFFFFFF, 3'd0); rst = 1'b1; out_ready = 1'b1; step();
    out_ready = 1'b0; step();
    rst = 1'b0;
    drive(1'b0, 32'h0, 3'd0);
    chk("rm_valid", 64'(out_valid64), 64'd0);
    chk("rm_imm64", out_imm64, 64'd0);
    chk("rm_imm32", 64'(out_imm32), 64'd0);
    chk("rm_instr", 64'(out_instr64), 64'd0);
    chk("rm_ready", 64'(in_ready64), 64'd1);
    out_ready = 1'b1; step(); step();
    chk("rm_no_stale", 64'(out_valid32), 64'd0);

    // Mixed stream with irregular valid and out_ready; the model checks each cycle.
    rdy_pat = 16'b1011_0011_1101_0110;
    for (int i = 0; i < 32; i++) begin
      out_ready = rdy_pat[i % 16];
      drive((i % 5) != 3, v_ins[i % NV], v_src[i % NV]);
      step();
    end
    drive(1'b0, 32'h0, 3'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("mix_drained", 64'(out_valid32), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
